// File: rtl/axi_lite_master_cmd.sv
// Purpose: single-outstanding AXI4-Lite master; one cmd -> one AW/W/B or AR/R transaction -> one rsp.
// Latency: zero-wait slave gives rsp_valid two edges after cmd acceptance; at least 4 cycles per transaction.
// Backpressure: cmd_ready only in IDLE; AXI valids and rsp_* hold until their own handshakes.
// Ports: ACLK/ARESET (sync, active-high); cmd_* request in; rsp_* result out; err_count is a
//        saturating count of non-OKAY B/R responses; M_AXI_* is the AXI4-Lite master port
//        (rlast is accepted but unused).
module axi_lite_master_cmd #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]              M_AXI_awprot,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]              M_AXI_arprot,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  input  logic                    M_AXI_rlast,
  output logic                    M_AXI_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic        aw_hs;
  logic        w_hs;
  logic [15:0] err_sat_inc;
  logic        unused_rlast;

  assign M_AXI_awprot = PROT;
  assign M_AXI_arprot = PROT;
  assign unused_rlast = M_AXI_rlast;

  assign aw_hs = M_AXI_awvalid && M_AXI_awready;
  assign w_hs  = M_AXI_wvalid && M_AXI_wready;

  // Counter value after one more error, pinned at all-ones.
  assign err_sat_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_count     <= 16'd0;
      M_AXI_awaddr  <= '0;
      M_AXI_awvalid <= 1'b0;
      M_AXI_wdata   <= '0;
      M_AXI_wstrb   <= '0;
      M_AXI_wvalid  <= 1'b0;
      M_AXI_bready  <= 1'b0;
      M_AXI_araddr  <= '0;
      M_AXI_arvalid <= 1'b0;
      M_AXI_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Raised on the first edge out of reset; the handshake branch below overrides it.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              M_AXI_awaddr  <= cmd_addr;
              M_AXI_wdata   <= cmd_wdata;
              M_AXI_wstrb   <= cmd_wstrb;
              M_AXI_awvalid <= 1'b1;
              M_AXI_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              M_AXI_araddr  <= cmd_addr;
              M_AXI_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W complete independently; the current-cycle handshakes count
          // so that a same-cycle AW+W moves on without an extra cycle.
          if (aw_hs) begin
            M_AXI_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            M_AXI_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (M_AXI_bvalid && M_AXI_bready) begin
            M_AXI_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_bresp;
            if (M_AXI_bresp != 2'b00) err_count <= err_sat_inc;
            state        <= RSP;
          end
        end

        RD_REQ: begin
          if (M_AXI_arvalid && M_AXI_arready) begin
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (M_AXI_rvalid && M_AXI_rready) begin
            M_AXI_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= M_AXI_rdata;
            rsp_resp     <= M_AXI_rresp;
            if (M_AXI_rresp != 2'b00) err_count <= err_sat_inc;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Bench for axi_lite_master_cmd: directed scenarios plus a randomized run against a
// word-array reference model and a cycle-level AXI4-Lite slave with programmable delays.
module tb_axi_lite_master_cmd;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_write;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr;
  logic [2:0]  M_AXI_awprot, M_AXI_arprot;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready;
  logic        M_AXI_awready = 1'b0, M_AXI_wready = 1'b0, M_AXI_bvalid = 1'b0;
  logic        M_AXI_arready = 1'b0, M_AXI_rvalid = 1'b0, M_AXI_rlast = 1'b1;
  logic [1:0]  M_AXI_bresp = 2'b00, M_AXI_rresp = 2'b00;
  logic [31:0] M_AXI_rdata = '0;

  axi_lite_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awvalid(M_AXI_awvalid),
    .M_AXI_awready(M_AXI_awready), .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .M_AXI_araddr(M_AXI_araddr),
    .M_AXI_arprot(M_AXI_arprot), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rready(M_AXI_rready)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:7];       // slave storage, written only from what the DUT presents on AW/W
  logic [31:0] ref_mem [0:7];   // expected storage, written only from the commands issued
  logic [15:0] exp_err = 16'd0;

  typedef struct packed {
    bit          timeout;
    int          n_aw, n_w, n_b, n_ar, n_r;
    bit          bad_stable, bad_payload, bad_early, bad_hold;
    bit          first_ok, idle_after;
    int          lat;           // negedges from the accept decision to first rsp_valid
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err;
  } obs_t;

  // One command through the DUT while acting as the AXI slave. Inputs change at negedges;
  // a handshake is recorded when valid and ready are both presented for the next posedge.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d, input logic [1:0] resp, input int hold,
                         output obs_t o);
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0, hold_c = 0, acc_cyc = -100;
    bit cmd_done = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    bit rsp_seen = 0, done = 0, aw_pend = 0, w_pend = 0, ar_pend = 0, both_p, ar_p;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    o = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge ACLK);
      both_p = aw_hs && w_hs;
      ar_p   = ar_hs;
      if (cyc == acc_cyc + 1)
        o.first_ok = wr ? (M_AXI_awvalid && M_AXI_wvalid && !M_AXI_arvalid)
                        : (M_AXI_arvalid && !M_AXI_awvalid && !M_AXI_wvalid);
      if ((aw_pend && !M_AXI_awvalid) || (w_pend && !M_AXI_wvalid) || (ar_pend && !M_AXI_arvalid))
        o.bad_stable = 1;
      if ((M_AXI_awvalid && M_AXI_awaddr !== addr) || (M_AXI_arvalid && M_AXI_araddr !== addr) ||
          (M_AXI_wvalid && (M_AXI_wdata !== data || M_AXI_wstrb !== strb)))
        o.bad_payload = 1;
      if ((M_AXI_bready && !both_p) || (M_AXI_rready && !ar_p)) o.bad_early = 1;
      if (rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1; o.lat = cyc - acc_cyc;
          o.rsp_write = rsp_write; o.rsp_rdata = rsp_rdata; o.rsp_resp = rsp_resp; o.err = err_count;
        end else if (rsp_write !== o.rsp_write || rsp_rdata !== o.rsp_rdata ||
                     rsp_resp !== o.rsp_resp || err_count !== o.err) o.bad_hold = 1;
        if (M_AXI_awvalid || M_AXI_wvalid || M_AXI_arvalid || cmd_ready) o.bad_hold = 1;
      end
      // response consumer
      if (rsp_seen) begin
        if (hold_c < hold) begin rsp_ready = 0; hold_c++; end
        else begin rsp_ready = 1; done = 1; end
      end else rsp_ready = 0;
      // command producer; junk commands are offered while the response is held off
      if (!cmd_done) begin
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        if (cmd_ready) begin cmd_done = 1; acc_cyc = cyc; end
      end else if (rsp_seen && !done) begin
        cmd_valid = 1; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
      end else cmd_valid = 0;
      // AW / W / AR channels: ready once the programmed number of waiting cycles elapsed
      M_AXI_awready = (aw_c >= aw_d); if (M_AXI_awvalid && !M_AXI_awready) aw_c++;
      aw_pend = M_AXI_awvalid && !M_AXI_awready;
      if (M_AXI_awvalid && M_AXI_awready) begin o.n_aw++; aw_hs = 1; cap_awaddr = M_AXI_awaddr; end
      M_AXI_wready = (w_c >= w_d); if (M_AXI_wvalid && !M_AXI_wready) w_c++;
      w_pend = M_AXI_wvalid && !M_AXI_wready;
      if (M_AXI_wvalid && M_AXI_wready) begin
        o.n_w++; w_hs = 1; cap_wdata = M_AXI_wdata; cap_wstrb = M_AXI_wstrb;
      end
      M_AXI_arready = (ar_c >= ar_d); if (M_AXI_arvalid && !M_AXI_arready) ar_c++;
      ar_pend = M_AXI_arvalid && !M_AXI_arready;
      if (M_AXI_arvalid && M_AXI_arready) begin o.n_ar++; ar_hs = 1; cap_araddr = M_AXI_araddr; end
      // B channel: raised b_d cycles after both AW and W completed, held until bready
      if (both_p && !b_hs) begin
        if (b_c >= b_d) begin
          M_AXI_bvalid = 1; M_AXI_bresp = resp;
          if (M_AXI_bready) begin
            b_hs = 1; o.n_b++;
            for (int b = 0; b < 4; b++)
              if (cap_wstrb[b]) mem[cap_awaddr[4:2]][8*b +: 8] = cap_wdata[8*b +: 8];
          end
        end else begin M_AXI_bvalid = 0; b_c++; end
      end else M_AXI_bvalid = 0;
      // R channel: raised r_d cycles after AR completed
      if (ar_p && !r_hs) begin
        if (r_c >= r_d) begin
          M_AXI_rvalid = 1; M_AXI_rresp = resp; M_AXI_rdata = mem[cap_araddr[4:2]];
          if (M_AXI_rready) begin r_hs = 1; o.n_r++; end
        end else begin M_AXI_rvalid = 0; r_c++; end
      end else M_AXI_rvalid = 0;
    end
    o.timeout = !done;
    @(negedge ACLK);
    rsp_ready = 0; cmd_valid = 0; M_AXI_bvalid = 0; M_AXI_rvalid = 0;
    o.idle_after = cmd_ready && !rsp_valid;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge ACLK);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    checks++; if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL rst_valids got %b want 000000",
        {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready, rsp_valid}); end
    checks++; if ({rsp_write, rsp_resp, rsp_rdata} !== 35'd0) begin errors++; $display("FAIL rst_rsp got %b/%h/%h want 0", rsp_write, rsp_resp, rsp_rdata); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err got %h want 0", err_count); end
    checks++; if ({M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb, M_AXI_araddr} !== 100'd0) begin
      errors++; $display("FAIL rst_addr got %h %h %h %h want 0", M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb, M_AXI_araddr); end
    checks++; if ({M_AXI_awprot, M_AXI_arprot} !== 6'b0) begin errors++; $display("FAIL rst_prot got %b want 0", {M_AXI_awprot, M_AXI_arprot}); end
    ARESET = 0;
    @(negedge ACLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_same_cycle;
    obs_t o;
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, o);
    checks++; if (o.timeout) begin errors++; $display("FAIL wr0_timeout got 1 want 0"); end
    checks++; if (o.n_aw !== 1 || o.n_w !== 1 || o.n_b !== 1 || o.n_ar !== 0) begin
      errors++; $display("FAIL wr0_hs_counts got aw%0d w%0d b%0d ar%0d want 1 1 1 0", o.n_aw, o.n_w, o.n_b, o.n_ar); end
    checks++; if (o.bad_payload) begin errors++; $display("FAIL wr0_payload got bad want awaddr 10 data deadbeef"); end
    checks++; if (!o.first_ok) begin errors++; $display("FAIL wr0_valid_after_accept got 0 want 1"); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL wr0_latency got %0d want 3", o.lat); end
    checks++; if ({o.rsp_write, o.rsp_resp, o.rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin
      errors++; $display("FAIL wr0_rsp got %b/%h/%h want 1/0/0", o.rsp_write, o.rsp_resp, o.rsp_rdata); end
    checks++; if (o.err !== 16'd0) begin errors++; $display("FAIL wr0_err got %h want 0", o.err); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr0_mem got %h want deadbeef", mem[4]); end
    checks++; if (!o.idle_after) begin errors++; $display("FAIL wr0_idle_after got 0 want 1"); end
  endtask

  task automatic test_w_before_aw;
    obs_t o;
    run_txn(1, 32'h14, 32'h12345678, 4'hF, 3, 0, 1, 0, 0, 2'b00, 0, o);
    checks++; if (o.timeout || o.n_aw !== 1 || o.n_w !== 1 || o.n_b !== 1) begin
      errors++; $display("FAIL wfirst_hs got to%0d aw%0d w%0d b%0d want 0 1 1 1", o.timeout, o.n_aw, o.n_w, o.n_b); end
    checks++; if (o.bad_stable || o.bad_payload) begin errors++; $display("FAIL wfirst_stable got %b%b want 00", o.bad_stable, o.bad_payload); end
    checks++; if (o.bad_early) begin errors++; $display("FAIL wfirst_bready_early got 1 want 0"); end
    checks++; if (mem[5] !== 32'h12345678) begin errors++; $display("FAIL wfirst_mem got %h want 12345678", mem[5]); end
  endtask

  task automatic test_read_delay;
    obs_t o;
    run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 2, 2, 2'b00, 0, o);
    checks++; if (o.timeout || o.n_ar !== 1 || o.n_r !== 1 || o.n_aw !== 0) begin
      errors++; $display("FAIL rd_hs got to%0d ar%0d r%0d aw%0d want 0 1 1 0", o.timeout, o.n_ar, o.n_r, o.n_aw); end
    checks++; if (o.bad_stable || o.bad_payload || o.bad_early) begin
      errors++; $display("FAIL rd_arvalid_stable got %b%b%b want 000", o.bad_stable, o.bad_payload, o.bad_early); end
    checks++; if (o.rsp_rdata !== 32'hDEADBEEF || o.rsp_write !== 1'b0) begin
      errors++; $display("FAIL rd_rsp got %h/%b want deadbeef/0", o.rsp_rdata, o.rsp_write); end
  endtask

  task automatic test_partial_write;
    obs_t o;
    run_txn(1, 32'h10, 32'h0000AB00, 4'b0010, 0, 0, 0, 0, 0, 2'b00, 0, o);
    checks++; if (o.timeout || o.rsp_resp !== 2'b00) begin errors++; $display("FAIL pw_write got to%0d resp %h want 0 0", o.timeout, o.rsp_resp); end
    run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, o);
    checks++; if (o.rsp_rdata !== 32'hDEADABEF) begin errors++; $display("FAIL pw_readback got %h want deadabef", o.rsp_rdata); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL pw_read_latency got %0d want 3", o.lat); end
  endtask

  task automatic test_errors;
    obs_t o;
    run_txn(1, 32'h18, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b10, 0, o);
    checks++; if (o.rsp_resp !== 2'b10 || o.err !== 16'd1) begin errors++; $display("FAIL err_bresp got %h cnt %h want 2 cnt 1", o.rsp_resp, o.err); end
    run_txn(0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b11, 0, o);
    checks++; if (o.rsp_resp !== 2'b11 || o.err !== 16'd2) begin errors++; $display("FAIL err_rresp got %h cnt %h want 3 cnt 2", o.rsp_resp, o.err); end
    checks++; if (o.rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL err_rdata got %h want cafef00d", o.rsp_rdata); end
    // Preload near the top of the range while idle, then push past it.
    @(negedge ACLK);
    force dut.err_count = 16'hFFFE;
    @(posedge ACLK); #1;
    release dut.err_count;
    run_txn(1, 32'h18, 32'h1, 4'h1, 0, 0, 0, 0, 0, 2'b10, 0, o);
    checks++; if (o.err !== 16'hFFFF) begin errors++; $display("FAIL err_reach_max got %h want ffff", o.err); end
    run_txn(0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 0, o);
    checks++; if (o.err !== 16'hFFFF) begin errors++; $display("FAIL err_saturate got %h want ffff", o.err); end
    exp_err = 16'hFFFF;
  endtask

  task automatic test_rsp_hold;
    obs_t o;
    run_txn(1, 32'h1C, 32'hA5A5A5A5, 4'hF, 1, 1, 0, 0, 0, 2'b00, 5, o);
    checks++; if (o.bad_hold) begin errors++; $display("FAIL hold_stable got unstable/accepted want stable"); end
    checks++; if (o.timeout || o.n_aw !== 1 || o.n_w !== 1 || o.n_ar !== 0) begin
      errors++; $display("FAIL hold_hs got to%0d aw%0d w%0d ar%0d want 0 1 1 0", o.timeout, o.n_aw, o.n_w, o.n_ar); end
    checks++; if (o.err !== exp_err) begin errors++; $display("FAIL hold_err got %h want %h", o.err, exp_err); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    bit   saw_rsp = 0;
    M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_bvalid = 0;
    @(negedge ACLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_ready got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h08; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 0;
    repeat (2) @(negedge ACLK);
    checks++; if (!(M_AXI_awvalid && M_AXI_wvalid)) begin
      errors++; $display("FAIL mid_in_wr_req got aw%b w%b want 1 1", M_AXI_awvalid, M_AXI_wvalid); end
    ARESET = 1;
    @(negedge ACLK);
    checks++; if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL mid_rst_valids got %b want 000000",
        {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready, rsp_valid}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_rst_err got %h want 0", err_count); end
    ARESET = 0;
    exp_err = 16'd0;
    rsp_ready = 1;
    repeat (6) begin @(negedge ACLK); if (rsp_valid) saw_rsp = 1; end
    rsp_ready = 0;
    checks++; if (saw_rsp) begin errors++; $display("FAIL mid_no_rsp got rsp_valid want none"); end
    checks++; if (mem[2] !== 32'h0) begin errors++; $display("FAIL mid_no_write got %h want 0", mem[2]); end
    run_txn(1, 32'h08, 32'h0BADC0DE, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, o);
    checks++; if (o.timeout || o.n_aw !== 1 || o.n_b !== 1 || o.rsp_write !== 1'b1) begin
      errors++; $display("FAIL mid_fresh_cmd got to%0d aw%0d b%0d wr%b want 0 1 1 1", o.timeout, o.n_aw, o.n_b, o.rsp_write); end
    checks++; if (mem[2] !== 32'h0BADC0DE) begin errors++; $display("FAIL mid_fresh_mem got %h want 0badc0de", mem[2]); end
  endtask

  task automatic test_random;
    obs_t        o;
    bit          wr;
    int          idx, aw_d, w_d, b_d, ar_d, r_d, hold;
    logic [31:0] addr, data, exp_rd;
    logic [3:0]  strb;
    logic [1:0]  resp;
    for (int i = 0; i < 48; i++) begin
      wr   = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      idx  = (i < 8) ? i : int'($urandom_range(0, 7));
      addr = 32'(idx) << 2;
      data = $urandom;
      strb = (i < 8) ? 4'hF : 4'($urandom_range(0, 15));
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (resp != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      exp_rd = wr ? 32'h0 : ref_mem[idx];
      if (wr) for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      run_txn(wr, addr, data, strb, aw_d, w_d, b_d, ar_d, r_d, resp, hold, o);
      checks++; if (o.timeout) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", i); end
      checks++; if (wr ? (o.n_aw !== 1 || o.n_w !== 1 || o.n_b !== 1 || o.n_ar !== 0)
                       : (o.n_ar !== 1 || o.n_r !== 1 || o.n_aw !== 0 || o.n_w !== 0)) begin
        errors++; $display("FAIL rnd%0d_hs got aw%0d w%0d b%0d ar%0d r%0d want one txn wr=%0d", i, o.n_aw, o.n_w, o.n_b, o.n_ar, o.n_r, wr); end
      checks++; if (o.bad_stable || o.bad_payload || o.bad_early || o.bad_hold || !o.first_ok) begin
        errors++; $display("FAIL rnd%0d_protocol got st%b pl%b early%b hold%b first%b want 0 0 0 0 1",
          i, o.bad_stable, o.bad_payload, o.bad_early, o.bad_hold, o.first_ok); end
      checks++; if ({o.rsp_write, o.rsp_resp, o.rsp_rdata} !== {wr, resp, exp_rd}) begin
        errors++; $display("FAIL rnd%0d_rsp got %b/%h/%h want %b/%h/%h", i, o.rsp_write, o.rsp_resp, o.rsp_rdata, wr, resp, exp_rd); end
      checks++; if (o.err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got %h want %h", i, o.err, exp_err); end
      checks++; if (!o.idle_after) begin errors++; $display("FAIL rnd%0d_idle_after got 0 want 1", i); end
      if (wr) begin
        checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rnd%0d_mem got %h want %h", i, mem[idx], ref_mem[idx]); end
      end
      if (wr ? (aw_d == 0 && w_d == 0 && b_d == 0) : (ar_d == 0 && r_d == 0)) begin
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL rnd%0d_latency got %0d want 3", i, o.lat); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_delay();
    test_partial_write();
    test_errors();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
